complex_nr_accumulator: RTL and testbench
=========================================

Name: complex_nr_accumulator

Overview:
Downstream consumer of the complex number multiplier's result stream (res_val/res_ready handshake).
- Sums acc_len consecutive complex products (re and im separately) with saturating signed arithmetic.
- Presents each finished sum on a valid/ready output port.
- Forms the complex dot-product / MAC back end of the multiplier datapath.

Parameters:
DATA_WIDTH, 8, operand width at the multiplier input; used only to derive defaults.
RES_WIDTH, 2*DATA_WIDTH+2, width of each signed (two's complement) product component from the multiplier.
ACC_WIDTH, RES_WIDTH+4, width of each signed accumulator component; must be >= RES_WIDTH.
LEN_WIDTH, 8, width of acc_len.

Ports:
clk  input  1  clock; all logic on posedge
sw_rst  input  1  synchronous reset, active-high
clear  input  1  abort the current sum or drop the pending result
res_val  input  1  product valid from multiplier
res_ready  output  1  accumulator accepts a product
res_re  input  RES_WIDTH  product real part, signed
res_im  input  RES_WIDTH  product imaginary part, signed
acc_len  input  LEN_WIDTH  products per sum; 0 is treated as 1
acc_val  output  1  sum valid
acc_ready  input  1  consumer takes the sum
acc_re  output  ACC_WIDTH  sum real part, signed
acc_im  output  ACC_WIDTH  sum imaginary part, signed
acc_ovf  output  1  saturation occurred during this sum
busy  output  1  at least one product accepted into the current sum, or sum pending

Behaviour:
- Interface: one clock clk; reset sw_rst is synchronous and active-high.
- Reset (sw_rst=1 at posedge): state=ACCUM, count=0, acc_re=acc_im=0, acc_ovf=0, acc_val=0, busy=0. res_ready is 1 from the next cycle.
- Priority: sw_rst > clear > handshakes.
- FSM has two states, ACCUM and HOLD.
- ACCUM:
  - res_ready = ~clear (combinational). Accept = res_val & res_ready.
  - On accept with count==0: latch len_q = max(acc_len,1). acc_len is ignored at all other times.
  - On every accept: acc_re/acc_im <= sat(acc + sign-extended res), acc_ovf |= any saturation, count++.
  - If count == len_q-1 on accept: count<=0, state<=HOLD, acc_val<=1.
  - Latency: the final product is accepted in cycle N; acc_val=1 in cycle N+1.
- HOLD:
  - res_ready=0. acc_re/acc_im/acc_ovf are stable while acc_val & ~acc_ready.
  - On acc_val & acc_ready: acc_val<=0, acc_re/acc_im/acc_ovf<=0, state<=ACCUM.
  - One bubble cycle per sum; the next product can be accepted the cycle after the handshake.
- Saturation: compute the sum in ACC_WIDTH+1 bits.
  - Result > 2^(ACC_WIDTH-1)-1 clamps to the max.
  - Result < -2^(ACC_WIDTH-1) clamps to the min.
  - Re and im saturate independently; acc_ovf is sticky for the current sum.
- clear:
  - In ACCUM: zeroes acc, count and acc_ovf; no product is accepted that cycle.
  - In HOLD: drops the pending sum; acc_val=0 the next cycle, state<=ACCUM.
  - clear with simultaneous res_val: clear wins and the product is not consumed (res_ready=0).
- busy = (count!=0) | (state==HOLD).
- The block never drops or duplicates a product: exactly one accept per res_val&res_ready cycle.
- sw_rst mid-sum or in HOLD: everything returns to reset values; partial or pending results are lost.

Decomposition:
- Shared package complex_nr_pkg:
  - default DATA_WIDTH/RES_WIDTH/ACC_WIDTH constants
  - FSM state typedef (ACCUM, HOLD)
  - signed saturation limit constants
- Sub-module complex_nr_sat_add: one signed saturating adder (ACC_WIDTH + RES_WIDTH -> ACC_WIDTH, plus overflow flag), instantiated twice (re, im).

Test Plan:
- acc_len=1, one product (2,16) [from (2+3i)(4+2i)] -> acc_val=1 one cycle after accept, acc=(2,16), acc_ovf=0; acc_ready=1 clears acc_val next cycle.
- acc_len=3, products (2,16), (-5,7), (100,-20) back-to-back -> acc=(97,3), acc_val one cycle after the third accept, res_ready=0 while pending.
- Backpressure: sum (97,3) pending, acc_ready=0 for 5 cycles with res_val=1 -> outputs held constant, res_ready=0, no product consumed; after acc_ready=1 the pending product is accepted the cycle after the handshake.
- ACC_WIDTH=18, acc_len=2, products (-65025,130050) twice -> acc=(-130050,131071), acc_ovf=1; the following sum of (1,1) with acc_len=1 gives acc=(1,1), acc_ovf=0.
- acc_len=4, accept (5,5) twice, assert clear one cycle with res_val=1 -> no accept that cycle, busy=0; then four products (1,1) -> acc=(4,4).
- Sum pending in HOLD, sw_rst=1 for one cycle -> next cycle acc_val=0, acc=(0,0), busy=0, res_ready=1; acc_len=0 then one product (7,-7) -> acc=(7,-7).

Source files
------------

// File: rtl/complex_nr_pkg.sv
// Shared constants and types for the complex multiplier accumulator back end.
// Default widths, FSM state encoding and saturation limits live here.
package complex_nr_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RES_WIDTH  = 2 * DEF_DATA_WIDTH + 2;
  localparam int DEF_ACC_WIDTH  = DEF_RES_WIDTH + 4;
  localparam int DEF_LEN_WIDTH  = 8;

  // Saturation limits of the default-width accumulator.
  localparam longint DEF_ACC_MAX = (longint'(1) <<< (DEF_ACC_WIDTH - 1)) - 1;
  localparam longint DEF_ACC_MIN = -(longint'(1) <<< (DEF_ACC_WIDTH - 1));

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/complex_nr_sat_add.sv
// Signed saturating adder: ACC_WIDTH accumulator plus RES_WIDTH product,
// clamped back to ACC_WIDTH with an overflow flag.
module complex_nr_sat_add #(
  parameter int ACC_WIDTH = complex_nr_pkg::DEF_ACC_WIDTH,
  parameter int RES_WIDTH = complex_nr_pkg::DEF_RES_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] a,
  input  logic signed [RES_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        ovf
);

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] full;

  // One guard bit is enough: the top two bits disagree exactly when the
  // true sum left the ACC_WIDTH range.
  assign full = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-RES_WIDTH){b[RES_WIDTH-1]}}, b};
  assign ovf  = full[ACC_WIDTH] ^ full[ACC_WIDTH-1];
  assign sum  = !ovf ? full[ACC_WIDTH-1:0] : (full[ACC_WIDTH] ? SAT_MIN : SAT_MAX);

endmodule

// File: rtl/complex_nr_accumulator.sv
// Sums acc_len complex products with saturation and presents each finished
// sum on a valid/ready port; two-state FSM (ACCUM collects, HOLD presents).
module complex_nr_accumulator
  import complex_nr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RES_WIDTH  = 2 * DATA_WIDTH + 2,
  parameter int ACC_WIDTH  = RES_WIDTH + 4,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                        clk,
  input  logic                        sw_rst,
  input  logic                        clear,
  input  logic                        res_val,
  output logic                        res_ready,
  input  logic signed [RES_WIDTH-1:0] res_re,
  input  logic signed [RES_WIDTH-1:0] res_im,
  input  logic        [LEN_WIDTH-1:0] acc_len,
  output logic                        acc_val,
  input  logic                        acc_ready,
  output logic signed [ACC_WIDTH-1:0] acc_re,
  output logic signed [ACC_WIDTH-1:0] acc_im,
  output logic                        acc_ovf,
  output logic                        busy
);

  acc_state_t                  state;
  logic        [LEN_WIDTH-1:0] count;
  logic        [LEN_WIDTH-1:0] len_q;
  logic        [LEN_WIDTH-1:0] cur_len;
  logic signed [ACC_WIDTH-1:0] sum_re, sum_im;
  logic                        ovf_re, ovf_im;
  logic                        accept;
  logic                        last;

  complex_nr_sat_add #(.ACC_WIDTH(ACC_WIDTH), .RES_WIDTH(RES_WIDTH)) u_add_re (
    .a(acc_re), .b(res_re), .sum(sum_re), .ovf(ovf_re)
  );

  complex_nr_sat_add #(.ACC_WIDTH(ACC_WIDTH), .RES_WIDTH(RES_WIDTH)) u_add_im (
    .a(acc_im), .b(res_im), .sum(sum_im), .ovf(ovf_im)
  );

  assign res_ready = (state == ACCUM) && !clear;
  assign accept    = res_val && res_ready;
  assign busy      = (count != '0) || (state == HOLD);

  // The first product of a sum uses acc_len directly; later ones use the latched length.
  assign cur_len = (count != '0) ? len_q :
                   (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
  assign last    = (count == cur_len - LEN_WIDTH'(1));

  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state   <= ACCUM;
      count   <= '0;
      len_q   <= LEN_WIDTH'(1);
      acc_re  <= '0;
      acc_im  <= '0;
      acc_ovf <= 1'b0;
      acc_val <= 1'b0;
    end else if (clear) begin
      state   <= ACCUM;
      count   <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      acc_ovf <= 1'b0;
      acc_val <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_re  <= sum_re;
            acc_im  <= sum_im;
            acc_ovf <= acc_ovf | ovf_re | ovf_im;
            if (count == '0) len_q <= cur_len;
            if (last) begin
              count   <= '0;
              state   <= HOLD;
              acc_val <= 1'b1;
            end else begin
              count <= count + LEN_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state   <= ACCUM;
            acc_val <= 1'b0;
            acc_re  <= '0;
            acc_im  <= '0;
            acc_ovf <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_nr_accumulator.sv
// Directed bench for complex_nr_accumulator: inputs change 1ns after posedge,
// outputs are sampled there too, well away from the active edge.
module tb_complex_nr_accumulator;

  localparam int DW = 8;
  localparam int RW = 2 * DW + 2;
  localparam int AW = 18;
  localparam int LW = 8;

  logic                 clk = 1'b0;
  logic                 sw_rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 res_val = 1'b0;
  logic                 res_ready;
  logic signed [RW-1:0] res_re = '0;
  logic signed [RW-1:0] res_im = '0;
  logic        [LW-1:0] acc_len = LW'(1);
  logic                 acc_val;
  logic                 acc_ready = 1'b0;
  logic signed [AW-1:0] acc_re;
  logic signed [AW-1:0] acc_im;
  logic                 acc_ovf;
  logic                 busy;

  int tests = 0;
  int fails = 0;

  complex_nr_accumulator #(
    .DATA_WIDTH(DW), .RES_WIDTH(RW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .sw_rst(sw_rst), .clear(clear),
    .res_val(res_val), .res_ready(res_ready), .res_re(res_re), .res_im(res_im),
    .acc_len(acc_len), .acc_val(acc_val), .acc_ready(acc_ready),
    .acc_re(acc_re), .acc_im(acc_im), .acc_ovf(acc_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and wait (bounded) until it is accepted on a clock edge.
  task automatic push(input logic signed [RW-1:0] re, input logic signed [RW-1:0] im);
    bit done = 0;
    res_val = 1'b1;
    res_re  = re;
    res_im  = im;
    #1;
    for (int i = 0; i < 16 && !done; i++) begin
      if (res_ready) done = 1;
      step();
    end
    res_val = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL push_timeout: product (%0d,%0d) never accepted", re, im);
    end
  endtask

  task automatic expect_sum(input string name, input int ere, input int eim, input bit eovf);
    tests++;
    if ({acc_val, acc_ovf} !== {1'b1, eovf} || acc_re !== AW'(ere) || acc_im !== AW'(eim)) begin
      fails++;
      $display("FAIL %s: got val=%0b acc=(%0d,%0d) ovf=%0b, expected val=1 acc=(%0d,%0d) ovf=%0b",
               name, acc_val, acc_re, acc_im, acc_ovf, ere, eim, eovf);
    end
  endtask

  task automatic drain(input string name);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    tests++;
    if ({acc_val, acc_ovf, busy} !== 3'b000 || acc_re !== '0 || acc_im !== '0) begin
      fails++;
      $display("FAIL %s_drain: got val=%0b acc=(%0d,%0d) ovf=%0b busy=%0b, expected all zero",
               name, acc_val, acc_re, acc_im, acc_ovf, busy);
    end
  endtask

  task automatic test_reset();
    step();
    sw_rst = 1'b0;
    #1;
    tests++;
    if ({acc_val, acc_ovf, busy, res_ready} !== 4'b0001 || acc_re !== '0 || acc_im !== '0) begin
      fails++;
      $display("FAIL reset: got val=%0b ovf=%0b busy=%0b ready=%0b acc=(%0d,%0d), expected 0,0,0,1 (0,0)",
               acc_val, acc_ovf, busy, res_ready, acc_re, acc_im);
    end
  endtask

  task automatic test_single();
    acc_len = LW'(1);
    push(18'sd2, 18'sd16);
    expect_sum("single", 2, 16, 1'b0);
    tests++;
    if (res_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_hold_ready: res_ready=%0b, expected 0", res_ready);
    end
    drain("single");
  endtask

  task automatic test_multi();
    acc_len = LW'(3);
    push(18'sd2, 18'sd16);
    acc_len = LW'(1);  // must be ignored mid-sum
    tests++;
    if ({acc_val, busy} !== 2'b01) begin
      fails++;
      $display("FAIL multi_first: val=%0b busy=%0b, expected val=0 busy=1", acc_val, busy);
    end
    push(-18'sd5, 18'sd7);
    tests++;
    if (acc_val !== 1'b0) begin
      fails++;
      $display("FAIL multi_second: val=%0b, expected 0", acc_val);
    end
    push(18'sd100, -18'sd20);
    expect_sum("multi", 97, 3, 1'b0);
  endtask

  // Continues from the (97,3) sum left pending by test_multi.
  task automatic test_backpressure();
    res_val = 1'b1;
    res_re  = 18'sd50;
    res_im  = 18'sd50;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if ({acc_val, res_ready} !== 2'b10 || acc_re !== AW'(97) || acc_im !== AW'(3)) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: val=%0b ready=%0b acc=(%0d,%0d), expected val=1 ready=0 (97,3)",
                 i, acc_val, res_ready, acc_re, acc_im);
      end
      step();
    end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    #1;
    tests++;
    if ({acc_val, res_ready} !== 2'b01 || acc_re !== '0) begin
      fails++;
      $display("FAIL backpressure_release: val=%0b ready=%0b acc_re=%0d, expected val=0 ready=1 0",
               acc_val, res_ready, acc_re);
    end
    step();
    res_val = 1'b0;
    expect_sum("backpressure_next", 50, 50, 1'b0);
    drain("backpressure");
  endtask

  task automatic test_saturation();
    acc_len = LW'(2);
    push(-18'sd65025, 18'sd130050);
    push(-18'sd65025, 18'sd130050);
    expect_sum("sat_pos", -130050, 131071, 1'b1);
    drain("sat_pos");
    acc_len = LW'(1);
    push(18'sd1, 18'sd1);
    expect_sum("sat_after", 1, 1, 1'b0);
    drain("sat_after");
    acc_len = LW'(2);
    push(-18'sd131072, 18'sd0);
    push(-18'sd1, 18'sd0);
    expect_sum("sat_neg", -131072, 0, 1'b1);
    drain("sat_neg");
  endtask

  task automatic test_clear();
    acc_len = LW'(4);
    push(18'sd5, 18'sd5);
    push(18'sd5, 18'sd5);
    res_val = 1'b1;
    res_re  = 18'sd9;
    res_im  = 18'sd9;
    clear   = 1'b1;
    #1;
    tests++;
    if (res_ready !== 1'b0) begin
      fails++;
      $display("FAIL clear_ready: res_ready=%0b, expected 0", res_ready);
    end
    step();
    clear   = 1'b0;
    res_val = 1'b0;
    tests++;
    if ({acc_val, busy} !== 2'b00 || acc_re !== '0 || acc_im !== '0) begin
      fails++;
      $display("FAIL clear_accum: val=%0b busy=%0b acc=(%0d,%0d), expected 0 0 (0,0)",
               acc_val, busy, acc_re, acc_im);
    end
    for (int i = 0; i < 4; i++) push(18'sd1, 18'sd1);
    expect_sum("clear_resum", 4, 4, 1'b0);
    drain("clear_resum");
    acc_len = LW'(1);
    push(18'sd3, 18'sd3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if ({acc_val, busy} !== 2'b00 || acc_re !== '0) begin
      fails++;
      $display("FAIL clear_hold: val=%0b busy=%0b acc_re=%0d, expected 0 0 0", acc_val, busy, acc_re);
    end
  endtask

  task automatic test_reset_in_hold();
    acc_len = LW'(1);
    push(18'sd8, 18'sd8);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    #1;
    tests++;
    if ({acc_val, busy, res_ready} !== 3'b001 || acc_re !== '0 || acc_im !== '0) begin
      fails++;
      $display("FAIL reset_hold: val=%0b busy=%0b ready=%0b acc=(%0d,%0d), expected 0 0 1 (0,0)",
               acc_val, busy, res_ready, acc_re, acc_im);
    end
    acc_len = LW'(0);
    push(18'sd7, -18'sd7);
    expect_sum("len_zero", 7, -7, 1'b0);
    drain("len_zero");
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_saturation();
    test_clear();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
